bidir_port_ctrl: RTL and testbench
==================================

BIDIR_PORT_CTRL -- requirements
Module: bidir_port_ctrl

Sequences direction and turnaround for the half-duplex line served by the bidirectional buffer. Drives that buffer's direction control (line_oe) and its outbound data. Captures inbound data.

Interface
REQ-001 Parameter WIDTH, default 8, data width of line and byte paths.
REQ-002 Parameter TURN_CYCLES, default 2, dead cycles (line_oe=0) inserted at each direction change; legal range 1..15.
REQ-003 Parameter MAX_BURST, default 16, maximum bytes per transmit burst; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 tx_valid  input  1  local source has a byte to send.
REQ-007 tx_data  input  WIDTH  byte to send, qualified by tx_valid.
REQ-008 tx_ready  output  1  controller accepts tx_data this cycle.
REQ-009 peer_req  input  1  far end requests the line for receive.
REQ-010 peer_valid  input  1  far end drives a valid byte on line_in this cycle.
REQ-011 line_in  input  WIDTH  sampled line value from the buffer.
REQ-012 line_out  output  WIDTH  registered byte presented to the buffer.
REQ-013 line_oe  output  1  registered direction control: 1 = drive line, 0 = release.
REQ-014 rx_valid  output  1  one-cycle pulse, rx_data holds a received byte.
REQ-015 rx_data  output  WIDTH  registered received byte.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, TURN_TX, TX, DRAIN, TURN_RX, RX.
REQ-018 IDLE: if peer_req=1 -> RX; else if tx_valid=1 -> TURN_TX; peer_req wins when both high.
REQ-019 TURN_TX: line_oe=0; stay exactly TURN_CYCLES cycles, then -> TX; tx_valid dropping here does not abort.
REQ-020 TX: line_oe=1, tx_ready=1 combinationally; each cycle with tx_valid=1 accepts one byte, line_out <= tx_data, burst count +1.
REQ-021 TX exits to DRAIN on the first cycle with tx_valid=0, or on the edge where the MAX_BURST-th byte is accepted; peer_req is ignored in TX.
REQ-022 DRAIN: one cycle, line_oe=1, line_out holds last byte, tx_ready=0; then -> TURN_RX.
REQ-023 TURN_RX: line_oe=0 for exactly TURN_CYCLES cycles, then -> IDLE.
REQ-024 RX: line_oe=0, tx_ready=0; each cycle with peer_valid=1, rx_data <= line_in and rx_valid=1 on the following cycle (latency 1); -> IDLE on the first cycle with peer_req=0, and peer_valid is ignored in that same cycle.
REQ-025 line_oe SHALL never go 0->1 without at least TURN_CYCLES preceding cycles at 0 since leaving RX or reset.
REQ-026 line_out SHALL change only on an accepted tx handshake; it retains its value in all other states.
REQ-027 Burst counter SHALL clear on entry to TURN_TX and SHALL be 8 bits wide; no wrap occurs because MAX_BURST<=255.
REQ-028 tx_ready SHALL be 0 in every state except TX.

Reset
REQ-029 On rst=1, immediately and regardless of clk: state=IDLE, line_oe=0, line_out=0, rx_valid=0, rx_data=0, busy=0, burst count=0, turn counter=0.
REQ-030 Reset asserted mid-TX SHALL release the line (line_oe=0) without a DRAIN or turnaround cycle; the byte in flight is discarded.
REQ-031 After rst deasserts, first transition out of IDLE SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-032 Reset: rst=1 during TX with line_oe=1 -> line_oe, line_out, busy all 0 before the next clk edge.
REQ-033 Single byte: tx_valid=1, tx_data=0xA5 in IDLE, TURN_CYCLES=2 -> line_oe=0 for 2 cycles, then 1 in TX; line_out=0xA5 one cycle after accept; DRAIN; line_oe=0 for 2 cycles; IDLE.
REQ-034 Burst limit: MAX_BURST=4, tx_valid held high with 0x01..0x06 -> exactly 4 bytes accepted (0x01..0x04), tx_ready falls after the 4th, then DRAIN and TURN_RX.
REQ-035 Receive: peer_req=1, peer_valid=1 with line_in 0x3C then 0xC3 -> rx_valid pulses on two consecutive cycles with rx_data 0x3C, 0xC3; line_oe stays 0 throughout.
REQ-036 Contention: peer_req=1 and tx_valid=1 in the same IDLE cycle -> RX entered, tx_ready stays 0; after peer_req drops, IDLE, then TURN_TX with TURN_CYCLES dead cycles.
REQ-037 Turnaround check: across all scenarios, monitor asserts no cycle where line_oe=1 while peer_valid=1, and the REQ-025 dead-cycle gap always holds.

Source files
------------

// File: rtl/bidir_port_ctrl_if.sv
// Bus bundle for the half-duplex line controller: local tx byte stream, far-end
// request/valid, line data both ways, buffer direction control, rx byte stream.
// master = the side that sources tx bytes, drives peer signals and samples the line;
// slave  = the controller itself.
interface bidir_port_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             tx_valid;
   logic [WIDTH-1:0] tx_data;
   logic             tx_ready;
   logic             peer_req;
   logic             peer_valid;
   logic [WIDTH-1:0] line_in;
   logic [WIDTH-1:0] line_out;
   logic             line_oe;
   logic             rx_valid;
   logic [WIDTH-1:0] rx_data;
   logic             busy;

   modport master (
      output tx_valid, tx_data, peer_req, peer_valid, line_in,
      input  tx_ready, line_out, line_oe, rx_valid, rx_data, busy
   );

   modport slave (
      input  tx_valid, tx_data, peer_req, peer_valid, line_in,
      output tx_ready, line_out, line_oe, rx_valid, rx_data, busy
   );
endinterface

// File: rtl/bidir_port_ctrl.sv
// Direction/turnaround sequencer for a half-duplex line behind a bidirectional buffer.
// Latency: tx byte reaches line_out 1 cycle after accept; rx byte reaches rx_data 1 cycle after sample.
// Backpressure: tx_ready only in TX; bursts capped at MAX_BURST; no backpressure on rx (pulse output).
//
// Ports:
//   clk     - single clock, all state changes on rising edge
//   rst     - asynchronous active-high reset
//   bus     - slave side of bidir_port_ctrl_if:
//             tx_valid/tx_data/tx_ready  local transmit byte stream
//             peer_req/peer_valid        far end requests line / drives a byte
//             line_in/line_out/line_oe   buffer data in, registered data out, registered direction
//             rx_valid/rx_data           registered received byte, one-cycle pulse
//             busy                       high whenever the FSM is not IDLE
module bidir_port_ctrl #(
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 2,    // 1..15
   parameter int MAX_BURST   = 16    // 1..255
) (
   input  logic               clk,
   input  logic               rst,
   bidir_port_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      TURN_TX = 3'd1,
      TX      = 3'd2,
      DRAIN   = 3'd3,
      TURN_RX = 3'd4,
      RX      = 3'd5
   } state_t;

   // Terminal values of the two counters, sized to the counter widths.
   localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES - 1);
   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   state_t           state_q;
   state_t           state_d;

   logic [3:0]       turn_cnt_q;
   logic [7:0]       burst_cnt_q;

   logic [WIDTH-1:0] line_out_q;
   logic             line_oe_q;
   logic             rx_valid_q;
   logic [WIDTH-1:0] rx_data_q;

   logic             tx_ready_c;
   logic             busy_c;
   logic             line_oe_d;

   logic             turn_done;
   logic             burst_last;
   logic             tx_accept;
   logic             rx_capture;
   logic             state_change;

   // Turn states last exactly TURN_CYCLES cycles: the counter starts at 0 on
   // entry and the exit is taken while it reads TURN_CYCLES-1.
   assign turn_done    = (turn_cnt_q == TURN_LAST);
   // The byte being accepted now is the MAX_BURST-th of this burst.
   assign burst_last   = (burst_cnt_q == BURST_LAST);
   assign tx_accept    = (state_q == TX) && bus.tx_valid;
   // In the cycle peer_req drops we leave RX and ignore peer_valid.
   assign rx_capture   = (state_q == RX) && bus.peer_req && bus.peer_valid;
   assign state_change = (state_d != state_q);

   //------------------------------------------------------------------
   // State register
   //------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   //------------------------------------------------------------------
   // Next-state logic
   //------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            // A far-end request wins over a pending local byte.
            if (bus.peer_req) begin
               state_d = RX;
            end else if (bus.tx_valid) begin
               state_d = TURN_TX;
            end
         end
         TURN_TX: begin
            // Committed once entered; tx_valid dropping does not abort.
            if (turn_done) begin
               state_d = TX;
            end
         end
         TX: begin
            // peer_req is not looked at here; the burst ends on its own.
            if (!bus.tx_valid || burst_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = TURN_RX;
         end
         TURN_RX: begin
            if (turn_done) begin
               state_d = IDLE;
            end
         end
         RX: begin
            if (!bus.peer_req) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   //------------------------------------------------------------------
   // Output logic
   //------------------------------------------------------------------
   always_comb begin
      tx_ready_c = 1'b0;
      busy_c     = 1'b0;
      line_oe_d  = 1'b0;
      if (state_q == TX) begin
         tx_ready_c = 1'b1;
      end
      if (state_q != IDLE) begin
         busy_c = 1'b1;
      end
      // line_oe is registered, so it is computed from the state being entered;
      // the register then matches the current state cycle for cycle.
      if ((state_d == TX) || (state_d == DRAIN)) begin
         line_oe_d = 1'b1;
      end
   end

   //------------------------------------------------------------------
   // Counters
   //------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         turn_cnt_q <= 4'd0;
      end else if (state_change) begin
         turn_cnt_q <= 4'd0;
      end else if ((state_q == TURN_TX) || (state_q == TURN_RX)) begin
         turn_cnt_q <= turn_cnt_q + 4'd1;
      end
   end

   // Cleared on entry to TURN_TX; the MAX_BURST cap keeps it from wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_cnt_q <= 8'd0;
      end else if ((state_d == TURN_TX) && (state_q != TURN_TX)) begin
         burst_cnt_q <= 8'd0;
      end else if (tx_accept) begin
         burst_cnt_q <= burst_cnt_q + 8'd1;
      end
   end

   //------------------------------------------------------------------
   // Line and receive datapath
   //------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_out_q <= '0;
         line_oe_q  <= 1'b0;
      end else begin
         line_oe_q <= line_oe_d;
         // line_out moves only on an accepted byte and holds otherwise,
         // so DRAIN keeps presenting the last byte of the burst.
         if (tx_accept) begin
            line_out_q <= bus.tx_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         rx_valid_q <= rx_capture;
         if (rx_capture) begin
            rx_data_q <= bus.line_in;
         end
      end
   end

   assign bus.tx_ready = tx_ready_c;
   assign bus.busy     = busy_c;
   assign bus.line_out = line_out_q;
   assign bus.line_oe  = line_oe_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Bench for bidir_port_ctrl: scoreboard of tx bytes, burst lengths and rx bytes,
// plus line-safety monitors. Stimulus changes 1 ns after posedge; the monitor samples on negedge.
module tb_bidir_port_ctrl;
   localparam int WIDTH       = 8;
   localparam int TURN_CYCLES = 2;
   localparam int MAX_BURST   = 4;
   localparam int BUDGET      = 200;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bidir_port_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

   bidir_port_ctrl #(
      .WIDTH      (WIDTH),
      .TURN_CYCLES(TURN_CYCLES),
      .MAX_BURST  (MAX_BURST)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model state: bytes in the order they must appear, and the
   // burst lengths the line must be split into.
   logic [7:0] exp_tx[$];
   logic [7:0] exp_rx[$];
   int         exp_chunk[$];
   bit         sb_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      compared++;
      mismatched++;
      $display("FAIL %s: %s", name, what);
   endtask

   //------------------------------------------------------------------
   // Monitor / scoreboard
   //------------------------------------------------------------------
   bit         hs_prev  = 1'b0;
   logic [7:0] hs_byte  = '0;
   bit         rdy_prev = 1'b0;
   int         run      = 0;
   int         zero_run = 0;
   bit         oe_prev  = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         hs_prev  = 1'b0;
         rdy_prev = 1'b0;
         run      = 0;
         zero_run = 0;
         oe_prev  = 1'b0;
      end else begin
         if (bus_if.peer_valid) check("oe_while_peer_valid", 32'(bus_if.line_oe), 32'd0);

         // Dead-cycle gap before every line_oe rise, counted since reset or RX.
         if (bus_if.peer_req) begin
            zero_run = 0;
         end else if (!bus_if.line_oe) begin
            zero_run++;
         end else begin
            if (!oe_prev) begin
               compared++;
               if (zero_run < TURN_CYCLES) begin
                  mismatched++;
                  $display("FAIL turn_gap: got %0d dead cycles, required at least %0d", zero_run, TURN_CYCLES);
               end
            end
            zero_run = 0;
         end
         oe_prev = bus_if.line_oe;

         if (!sb_en) begin
            hs_prev  = 1'b0;
            rdy_prev = 1'b0;
            run      = 0;
         end else begin
            if (hs_prev) check("line_out", 32'(bus_if.line_out), 32'(hs_byte));
            hs_prev = 1'b0;
            if (bus_if.tx_valid && bus_if.tx_ready) begin
               if (exp_tx.size() == 0) begin
                  fail_now("tx_accept", "byte accepted with none expected");
               end else begin
                  hs_byte = exp_tx.pop_front();
                  hs_prev = 1'b1;
               end
            end
            if (bus_if.tx_ready) begin
               if (bus_if.tx_valid) run++;
               rdy_prev = 1'b1;
            end else if (rdy_prev) begin
               if (exp_chunk.size() == 0) fail_now("burst_len", "burst ended with none expected");
               else check("burst_len", 32'(run), 32'(exp_chunk.pop_front()));
               run      = 0;
               rdy_prev = 1'b0;
            end
            if (bus_if.rx_valid) begin
               if (exp_rx.size() == 0) fail_now("rx_data", "rx_valid with no byte expected");
               else check("rx_data", 32'(bus_if.rx_data), 32'(exp_rx.pop_front()));
            end
         end
      end
   end

   //------------------------------------------------------------------
   // Stimulus helpers
   //------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus_if.busy && n < BUDGET) begin
         step();
         n++;
      end
      if (bus_if.busy) fail_now("wait_idle", "busy still 1 after budget, required 0");
   endtask

   // Offers n bytes back to back; the model splits them into MAX_BURST chunks.
   task automatic send_burst(input int n, input logic [7:0] first, input bit counting);
      logic [7:0] b;
      int         left;
      int         waited;
      left = n;
      while (left > MAX_BURST) begin
         exp_chunk.push_back(MAX_BURST);
         left -= MAX_BURST;
      end
      exp_chunk.push_back(left);
      for (int i = 0; i < n; i++) begin
         b = counting ? first + 8'(i) : 8'($urandom);
         exp_tx.push_back(b);
         bus_if.tx_valid = 1'b1;
         bus_if.tx_data  = b;
         waited = 0;
         while (!bus_if.tx_ready && waited < BUDGET) begin
            step();
            waited++;
         end
         if (!bus_if.tx_ready) begin
            fail_now("tx_wait", "tx_ready never rose, required 1");
            bus_if.tx_valid = 1'b0;
            return;
         end
         step();
      end
      bus_if.tx_valid = 1'b0;
   endtask

   // Claims the line from IDLE, sends n cycles of random peer_valid, then
   // drops peer_req with a junk byte that must be ignored.
   task automatic rx_session(input int n);
      logic pv;
      bus_if.peer_req = 1'b1;
      step();
      check("rx_busy", 32'(bus_if.busy), 32'd1);
      for (int i = 0; i < n; i++) begin
         pv = 1'($urandom_range(0, 1));
         bus_if.peer_valid = pv;
         bus_if.line_in    = 8'($urandom);
         if (pv) exp_rx.push_back(bus_if.line_in);
         step();
         check("rx_tx_ready", 32'(bus_if.tx_ready), 32'd0);
         check("rx_line_oe", 32'(bus_if.line_oe), 32'd0);
      end
      bus_if.peer_req   = 1'b0;
      bus_if.peer_valid = 1'($urandom_range(0, 1));
      bus_if.line_in    = 8'($urandom);
      step();
      bus_if.peer_valid = 1'b0;
   endtask

   //------------------------------------------------------------------
   // Main sequence
   //------------------------------------------------------------------
   initial begin
      int k;
      logic [7:0] rx_pat [2];
      rx_pat[0] = 8'h3C;
      rx_pat[1] = 8'hC3;

      rst               = 1'b1;
      bus_if.tx_valid   = 1'b0;
      bus_if.tx_data    = '0;
      bus_if.peer_req   = 1'b0;
      bus_if.peer_valid = 1'b0;
      bus_if.line_in    = '0;
      #1;
      check("reset_line_oe", 32'(bus_if.line_oe), 32'd0);
      check("reset_line_out", 32'(bus_if.line_out), 32'd0);
      check("reset_rx_valid", 32'(bus_if.rx_valid), 32'd0);
      check("reset_rx_data", 32'(bus_if.rx_data), 32'd0);
      check("reset_busy", 32'(bus_if.busy), 32'd0);
      check("reset_tx_ready", 32'(bus_if.tx_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      sb_en = 1'b1;
      step();

      // Single byte 0xA5 with exact turnaround timing.
      exp_tx.push_back(8'hA5);
      exp_chunk.push_back(1);
      bus_if.tx_valid = 1'b1;
      bus_if.tx_data  = 8'hA5;
      k = 0;
      while (!bus_if.tx_ready && k < BUDGET) begin
         check("single_dead_oe", 32'(bus_if.line_oe), 32'd0);
         step();
         k++;
      end
      check("single_dead_cycles", 32'(k), 32'(TURN_CYCLES + 1));
      check("single_tx_oe", 32'(bus_if.line_oe), 32'd1);
      step();
      bus_if.tx_valid = 1'b0;
      check("single_line_out", 32'(bus_if.line_out), 32'hA5);
      step();
      check("drain_oe", 32'(bus_if.line_oe), 32'd1);
      check("drain_tx_ready", 32'(bus_if.tx_ready), 32'd0);
      check("drain_line_out", 32'(bus_if.line_out), 32'hA5);
      for (int i = 0; i < TURN_CYCLES; i++) begin
         step();
         check("turn_rx_oe", 32'(bus_if.line_oe), 32'd0);
         check("turn_rx_busy", 32'(bus_if.busy), 32'd1);
      end
      step();
      check("back_to_idle", 32'(bus_if.busy), 32'd0);

      // Burst limit: six counting bytes must split 4 + 2.
      send_burst(6, 8'h01, 1'b1);
      wait_idle();

      // Directed receive of 0x3C, 0xC3.
      bus_if.peer_req = 1'b1;
      step();
      for (int i = 0; i < 2; i++) begin
         bus_if.peer_valid = 1'b1;
         bus_if.line_in    = rx_pat[i];
         exp_rx.push_back(rx_pat[i]);
         step();
         check("rx_pulse", 32'(bus_if.rx_valid), 32'd1);
         check("rx_byte", 32'(bus_if.rx_data), 32'(rx_pat[i]));
      end
      bus_if.peer_req   = 1'b0;
      bus_if.peer_valid = 1'b0;
      step();
      check("rx_pulse_end", 32'(bus_if.rx_valid), 32'd0);
      check("rx_exit_idle", 32'(bus_if.busy), 32'd0);

      // Contention: peer_req and tx_valid together in IDLE.
      wait_idle();
      exp_tx.push_back(8'hC7);
      exp_chunk.push_back(1);
      bus_if.tx_valid = 1'b1;
      bus_if.tx_data  = 8'hC7;
      rx_session(3);
      k = 0;
      while (!bus_if.tx_ready && k < BUDGET) begin
         step();
         k++;
      end
      check("contention_dead_cycles", 32'(k), 32'(TURN_CYCLES + 1));
      step();
      bus_if.tx_valid = 1'b0;
      wait_idle();

      // Randomized mix of bursts and receive sessions.
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 0) begin
            send_burst(int'($urandom_range(1, 10)), 8'h00, 1'b0);
         end else begin
            wait_idle();
            rx_session(int'($urandom_range(1, 6)));
         end
         repeat ($urandom_range(1, 3)) step();
      end
      wait_idle();
      repeat (3) step();

      // Reset in the middle of a burst releases the line at once.
      sb_en = 1'b0;
      bus_if.tx_valid = 1'b1;
      bus_if.tx_data  = 8'h77;
      k = 0;
      while (!bus_if.tx_ready && k < BUDGET) begin
         step();
         k++;
      end
      step();
      check("mid_tx_oe_before_rst", 32'(bus_if.line_oe), 32'd1);
      bus_if.tx_data = 8'h88;
      #3 rst = 1'b1;
      #1;
      check("rst_line_oe", 32'(bus_if.line_oe), 32'd0);
      check("rst_line_out", 32'(bus_if.line_out), 32'd0);
      check("rst_busy", 32'(bus_if.busy), 32'd0);
      check("rst_tx_ready", 32'(bus_if.tx_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("post_rst_still_idle", 32'(bus_if.busy), 32'd0);
      step();
      check("post_rst_first_move", 32'(bus_if.busy), 32'd1);
      bus_if.tx_valid = 1'b0;
      wait_idle();
      step();
      sb_en = 1'b1;
      step();

      send_burst(3, 8'h50, 1'b1);
      wait_idle();
      repeat (3) step();

      check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
      check("chunk_queue_empty", 32'(exp_chunk.size()), 32'd0);
      check("rx_queue_empty", 32'(exp_rx.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
